// File: rtl/run_timer.sv
// run_timer: game-time keeper for the dino game.
// Counts vsync frames during a run, keeps elapsed time as packed BCD mm:ss,
// latches the best run and drives the SevenSegment digit bus and enables.
// vsync comes from pclk, which is a divided copy of clk, so it is already
// synchronous to clk and needs only an edge detector.
module run_timer #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int BLINK_FRAMES   = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        game_active,
    input  logic        game_start,
    input  logic        show_best,
    output logic [15:0] nums,
    output logic [3:0]  digit_en,
    output logic        new_record
);

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        STOPPED
    } state_t;

    localparam logic [5:0]  FRAME_LAST = 6'(FRAMES_PER_SEC - 1);
    localparam logic [5:0]  BLINK_LAST = 6'(BLINK_FRAMES - 1);
    localparam logic [15:0] CUR_MAX    = 16'h9959;

    state_t      state;
    logic        vs_q;
    logic        ga_q;
    logic [5:0]  frame_cnt;
    logic [5:0]  blink_cnt;
    logic        blink_on;
    logic [15:0] cur;
    logic [15:0] best;

    logic tick;
    logic ga_fall;

    assign tick    = vsync & ~vs_q;
    assign ga_fall = ga_q & ~game_active;

    // One-second BCD increment of mm:ss; the caller stops at 99:59.
    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            if (t[7:4] == 4'd5) begin
                r[7:4] = 4'd0;
                if (t[11:8] == 4'd9) begin
                    r[11:8]  = 4'd0;
                    r[15:12] = t[15:12] + 4'd1;
                end else begin
                    r[11:8] = t[11:8] + 4'd1;
                end
            end else begin
                r[7:4] = t[7:4] + 4'd1;
            end
        end else begin
            r[3:0] = t[3:0] + 4'd1;
        end
        return r;
    endfunction

    // Delayed copies of vsync and game_active for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q <= 1'b0;
            ga_q <= 1'b0;
        end else begin
            vs_q <= vsync;
            ga_q <= game_active;
        end
    end

    // Run FSM: time counting, best-time latch and new-record blink timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur        <= 16'h0000;
            best       <= 16'h0000;
            frame_cnt  <= 6'd0;
            blink_cnt  <= 6'd0;
            blink_on   <= 1'b1;
            new_record <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cur       <= 16'h0000;
                    frame_cnt <= 6'd0;
                    if (game_start) begin
                        state      <= RUNNING;
                        new_record <= 1'b0;
                        blink_cnt  <= 6'd0;
                        blink_on   <= 1'b1;
                    end
                end

                RUNNING: begin
                    if (game_start) begin
                        cur       <= 16'h0000;
                        frame_cnt <= 6'd0;
                    end else if (ga_fall) begin
                        state <= STOPPED;
                        if (cur > best) begin
                            best       <= cur;
                            new_record <= 1'b1;
                        end
                    end else if (tick) begin
                        if (frame_cnt == FRAME_LAST) begin
                            frame_cnt <= 6'd0;
                            if (cur != CUR_MAX) begin
                                cur <= bcd_inc(cur);
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 6'd1;
                        end
                    end
                end

                STOPPED: begin
                    if (game_start) begin
                        state      <= RUNNING;
                        cur        <= 16'h0000;
                        frame_cnt  <= 6'd0;
                        new_record <= 1'b0;
                        blink_cnt  <= 6'd0;
                        blink_on   <= 1'b1;
                    end else if (new_record && tick) begin
                        if (blink_cnt == BLINK_LAST) begin
                            blink_cnt <= 6'd0;
                            blink_on  <= ~blink_on;
                        end else begin
                            blink_cnt <= blink_cnt + 6'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Registered display mux and digit enables for the SevenSegment driver.
    always_ff @(posedge clk) begin
        if (rst) begin
            nums     <= 16'h0000;
            digit_en <= 4'hF;
        end else begin
            nums <= (show_best && state != RUNNING) ? best : cur;
            if (show_best) begin
                digit_en <= 4'hF;
            end else if (state == STOPPED && new_record) begin
                digit_en <= blink_on ? 4'hF : 4'h0;
            end else begin
                digit_en <= 4'hF;
            end
        end
    end

endmodule

// File: tb/tb_run_timer.sv
// Testbench for run_timer: directed runs with hand-computed mm:ss values.
// A second instance with one frame per second reaches the 99:59 ceiling
// in a reasonable number of cycles.
module tb_run_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b0;
    logic        game_active = 1'b0;
    logic        game_start = 1'b0;
    logic        show_best = 1'b0;
    logic [15:0] nums;
    logic [3:0]  digit_en;
    logic        new_record;

    logic        vsync2 = 1'b0;
    logic        start2 = 1'b0;
    logic [15:0] nums2;
    logic [3:0]  digit_en2;
    logic        new_record2;

    int checks = 0;
    int errors = 0;

    run_timer dut (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .game_active(game_active),
        .game_start (game_start),
        .show_best  (show_best),
        .nums       (nums),
        .digit_en   (digit_en),
        .new_record (new_record)
    );

    run_timer #(.FRAMES_PER_SEC(1), .BLINK_FRAMES(2)) dut_fast (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync2),
        .game_active(game_active),
        .game_start (start2),
        .show_best  (show_best),
        .nums       (nums2),
        .digit_en   (digit_en2),
        .new_record (new_record2)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // n vsync pulses on the main instance, one cycle high, one cycle low.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) vsync = 1'b1;
            @(negedge clk) vsync = 1'b0;
        end
    endtask

    task automatic pulse_fast(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) vsync2 = 1'b1;
            @(negedge clk) vsync2 = 1'b0;
        end
    endtask

    task automatic start_run();
        @(negedge clk) game_start = 1'b1;
        @(negedge clk) game_start = 1'b0;
    endtask

    task automatic stop_run();
        @(negedge clk) game_active = 1'b0;
        wait_cycles(2);
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        wait_cycles(3);
        checkOutput("reset_nums", nums, 16'h0000);
        checkOutput("reset_digit_en", {12'h000, digit_en}, 16'h000F);
        checkOutput("reset_new_record", {15'h0, new_record}, 16'h0000);
        rst = 1'b0;
        game_active = 1'b1;

        // Saturation at 99:59 on the one-frame-per-second instance.
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        pulse_fast(5998);
        wait_cycles(2);
        checkOutput("sat_9958", nums2, 16'h9958);
        pulse_fast(1);
        wait_cycles(2);
        checkOutput("sat_9959", nums2, 16'h9959);
        pulse_fast(120);
        wait_cycles(2);
        checkOutput("sat_hold", nums2, 16'h9959);
        checkOutput("idle_ignores_ticks", nums, 16'h0000);

        // First run: seconds and minutes carry.
        start_run();
        applyStimulus(59);
        wait_cycles(2);
        checkOutput("frames_59", nums, 16'h0000);
        applyStimulus(1);
        wait_cycles(2);
        checkOutput("frames_60", nums, 16'h0001);
        applyStimulus(3540);
        wait_cycles(2);
        checkOutput("frames_3600", nums, 16'h0100);

        // Restart while running, then a 125-frame run that sets a record.
        start_run();
        wait_cycles(2);
        checkOutput("restart_clears", nums, 16'h0000);
        applyStimulus(125);
        wait_cycles(2);
        checkOutput("frames_125", nums, 16'h0002);
        stop_run();
        checkOutput("stop1_nums", nums, 16'h0002);
        checkOutput("stop1_record", {15'h0, new_record}, 16'h0001);
        checkOutput("blink_start_on", {12'h000, digit_en}, 16'h000F);
        applyStimulus(29);
        wait_cycles(2);
        checkOutput("blink_29_on", {12'h000, digit_en}, 16'h000F);
        applyStimulus(1);
        wait_cycles(2);
        checkOutput("blink_30_off", {12'h000, digit_en}, 16'h0000);
        checkOutput("stopped_frozen", nums, 16'h0002);
        @(negedge clk) show_best = 1'b1;
        wait_cycles(1);
        checkOutput("show_best_forces_en", {12'h000, digit_en}, 16'h000F);
        @(negedge clk) show_best = 1'b0;
        wait_cycles(1);
        checkOutput("blink_off_again", {12'h000, digit_en}, 16'h0000);
        applyStimulus(30);
        wait_cycles(2);
        checkOutput("blink_60_on", {12'h000, digit_en}, 16'h000F);

        // Second, shorter run: no record, show_best selects the best time.
        game_active = 1'b1;
        start_run();
        wait_cycles(2);
        checkOutput("start_clears_record", {15'h0, new_record}, 16'h0000);
        applyStimulus(60);
        stop_run();
        checkOutput("stop2_nums", nums, 16'h0001);
        checkOutput("stop2_no_record", {15'h0, new_record}, 16'h0000);
        checkOutput("stop2_digit_en", {12'h000, digit_en}, 16'h000F);
        @(negedge clk) show_best = 1'b1;
        wait_cycles(1);
        checkOutput("show_best_nums", nums, 16'h0002);
        checkOutput("show_best_en", {12'h000, digit_en}, 16'h000F);
        @(negedge clk) show_best = 1'b0;
        wait_cycles(1);
        checkOutput("show_cur_nums", nums, 16'h0001);

        // Tie with best, and a tick coinciding with the stop is discarded.
        game_active = 1'b1;
        start_run();
        applyStimulus(179);
        wait_cycles(2);
        checkOutput("frames_179", nums, 16'h0002);
        @(negedge clk) begin
            vsync = 1'b1;
            game_active = 1'b0;
        end
        @(negedge clk) vsync = 1'b0;
        wait_cycles(2);
        checkOutput("tick_at_stop_nums", nums, 16'h0002);
        checkOutput("tie_no_record", {15'h0, new_record}, 16'h0000);

        // game_start together with a tick: the start wins.
        game_active = 1'b1;
        start_run();
        applyStimulus(600);
        wait_cycles(2);
        checkOutput("frames_600", nums, 16'h0010);
        @(negedge clk) begin
            game_start = 1'b1;
            vsync = 1'b1;
        end
        @(negedge clk) begin
            game_start = 1'b0;
            vsync = 1'b0;
        end
        wait_cycles(2);
        checkOutput("start_with_tick", nums, 16'h0000);
        applyStimulus(59);
        wait_cycles(2);
        checkOutput("after_start_59", nums, 16'h0000);
        applyStimulus(1);
        wait_cycles(2);
        checkOutput("after_start_60", nums, 16'h0001);

        // Best of 00:30, then reset mid-run at 00:15.
        start_run();
        applyStimulus(1800);
        stop_run();
        checkOutput("best30_nums", nums, 16'h0030);
        checkOutput("best30_record", {15'h0, new_record}, 16'h0001);
        game_active = 1'b1;
        start_run();
        applyStimulus(900);
        wait_cycles(2);
        checkOutput("frames_900", nums, 16'h0015);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        checkOutput("rst_nums", nums, 16'h0000);
        checkOutput("rst_digit_en", {12'h000, digit_en}, 16'h000F);
        checkOutput("rst_record", {15'h0, new_record}, 16'h0000);
        checkOutput("rst_fast_nums", nums2, 16'h0000);
        @(negedge clk) show_best = 1'b1;
        wait_cycles(1);
        checkOutput("rst_best_cleared", nums, 16'h0000);
        @(negedge clk) show_best = 1'b0;
        applyStimulus(60);
        wait_cycles(2);
        checkOutput("rst_idle_ignores", nums, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/run_timer.md
# run_timer

Game-time keeper for the dino game. Counts display frames while a run is in progress and keeps the elapsed time as packed BCD mm:ss. Latches the best run time and drives the 16-bit digit bus and per-digit enables of the SevenSegment driver. It replaces the inline frame/second counter in the top level and sits between the game logic (`game_active`, `vsync`) and SevenSegment.

## Interface
- FRAMES_PER_SEC, default 60: vsync rising edges per elapsed second.
- BLINK_FRAMES, default 30: frames per blink half-period on a new record.

- clk  input  1  system clock (100 MHz); all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- vsync  input  1  VGA vertical sync; produced from the pclk domain, a divided copy of clk.
- game_active  input  1  high while the dino is alive and running.
- game_start  input  1  one-cycle pulse; begins a new run.
- show_best  input  1  level; requests the best time on the display.
- nums  output  16  {min_tens, min_ones, sec_tens, sec_ones}, BCD.
- digit_en  output  4  per-digit enable, bit 3 = min_tens; 0 blanks the digit.
- new_record  output  1  high after a run that beat the stored best.

## Operation
- Frame tick:
  - vs_q <= vsync every cycle.
  - tick = vsync & ~vs_q.
  - frame_cnt (6 bits) counts ticks, 0..FRAMES_PER_SEC-1.
- Current time `cur` is 16-bit BCD.
  - On frame_cnt wrap, increment with carries: sec_ones 9→0, sec_tens 5→0, min_ones 9→0, min_tens +1.
  - Saturates at 99:59: no further increment, frame_cnt keeps cycling.
- `best` is 16-bit BCD and is cleared only by rst.
  - Compared as unsigned binary. BCD ordering equals numeric ordering.
- FSM states: IDLE, RUNNING, STOPPED.
  - IDLE: cur=0.
    - game_start → RUNNING.
  - RUNNING: count on tick.
    - Falling edge of game_active (ga_q & ~game_active) → STOPPED.
    - On that transition, if cur > best: best <= cur, new_record <= 1.
    - game_start while RUNNING restarts the run: cur=0, frame_cnt=0, stays RUNNING, no best compare.
  - STOPPED: cur frozen.
    - game_start → RUNNING with cur=0, frame_cnt=0, new_record=0, blink_cnt=0.
- Display mux:
  - nums = best when show_best && state≠RUNNING; otherwise nums = cur.
- Blink:
  - In STOPPED with new_record=1, blink_cnt counts ticks 0..BLINK_FRAMES-1.
  - blink_on toggles on each wrap. digit_en = blink_on ? 4'hF : 4'h0.
  - In all other cases digit_en = 4'hF.
  - show_best forces digit_en = 4'hF.

## Timing
- All outputs are registered.
- Reset values: nums=16'h0000, digit_en=4'hF, new_record=0, state=IDLE, cur=best=0, frame_cnt=0, blink_cnt=0, blink_on=1, vs_q=0, ga_q=0.
- Tick latency:
  - Cycle N: vsync is first sampled high.
  - Cycle N+1: frame_cnt/cur update.
  - Cycle N+2: nums reflects the update.
- Stop latency: game_active low at cycle N → state=STOPPED and best/new_record updated at N+1, nums stable at N+2.
- Simultaneous events:
  - game_start with tick: the start wins and the tick is discarded (cur=0, frame_cnt=0).
  - game_start with game_active falling: the start wins, with no best update.
  - Tick in the same cycle as game_active falling: the tick is discarded, and the compare uses the pre-tick cur.
- cur == best on stop: no update, new_record stays 0. Strictly greater is required.
- rst mid-run: everything returns to its reset value next cycle, including best.
- show_best change takes effect on nums in 1 cycle.

## Test plan
- rst, game_start, then 60 vsync pulses with game_active=1 → nums=16'h0001 two cycles after the 60th rising edge. 3600 pulses → 16'h0100.
- Run 125 pulses, drop game_active → nums holds 16'h0002, best=16'h0002, new_record=1, digit_en alternates F/0 every 30 pulses.
- Second run of 60 pulses, stop, then show_best=1 → new_record=0, nums=16'h0001 while show_best=0 and 16'h0002 while show_best=1, digit_en=4'hF.
- Preload to 99:58 (force or long run), 120 more pulses → nums saturates at 16'h9959, no wrap to 0000.
- game_start asserted in the same cycle as a vsync rising edge at cur=16'h0010 → cur=16'h0000, frame_cnt=0.
- rst pulse mid-run at 16'h0015 with best=16'h0030 → next cycle nums=0, best=0, state IDLE, digit_en=4'hF, and further vsync edges are ignored.
